// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: shared state encodings and default timing constants for the SDRAM owner scheduler
package sdram_sched_pkg;

    typedef enum logic [2:0] {
        CAM         = 3'd0,
        REQ_NIOS    = 3'd1,
        NIOS_OWN    = 3'd2,
        REQ_ACCEL   = 3'd3,
        ACCEL_OWN   = 3'd4,
        ACCEL_YIELD = 3'd5,
        RELEASE     = 3'd6
    } state_t;

    localparam int CNT_W_DEF          = 16;
    localparam int ACCEL_SLICE_DEF    = 1024;
    localparam int CAM_GUARD_DEF      = 256;
    localparam int SWITCH_TIMEOUT_DEF = 64;

    // States that wait on the arbiter and are therefore covered by the switch timeout
    function automatic logic is_wait(state_t s);
        return s inside {REQ_NIOS, REQ_ACCEL, RELEASE};
    endfunction

endpackage

// File: rtl/sdram_owner_scheduler_if.sv
// sdram_owner_scheduler_if: requester/arbiter-facing signals of the SDRAM owner scheduler
interface sdram_owner_scheduler_if;

    logic       nios_req;
    logic       accel_req;
    logic       cam_busy;
    logic       NiosHasControl;
    logic       AccelHasControl;
    logic       CamHasControl;
    logic       RequestNiosControl;
    logic       RequestAccelControl;
    logic       nios_grant;
    logic       accel_grant;
    logic       accel_preempt;
    logic       switch_error;
    logic [2:0] state_dbg;

    modport master (
        input  nios_req, accel_req, cam_busy,
        input  NiosHasControl, AccelHasControl, CamHasControl,
        output RequestNiosControl, RequestAccelControl,
        output nios_grant, accel_grant, accel_preempt, switch_error, state_dbg
    );

    modport slave (
        output nios_req, accel_req, cam_busy,
        output NiosHasControl, AccelHasControl, CamHasControl,
        input  RequestNiosControl, RequestAccelControl,
        input  nios_grant, accel_grant, accel_preempt, switch_error, state_dbg
    );

endinterface

// File: rtl/sdram_sched_timer.sv
// sdram_sched_timer: loadable saturating counter (down to zero, or up to LIM) with a terminal flag
module sdram_sched_timer #(
    parameter int               CNT_W = 16,
    parameter bit               UP    = 1'b0,
    parameter logic [CNT_W-1:0] LIM   = '1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] val,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // Load wins over counting; counting stops at the terminal value
    always_ff @(posedge clk or posedge Reset)
        if (Reset)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (en && !done)
            cnt <= UP ? cnt + 1'b1 : cnt - 1'b1;

    assign done = UP ? (cnt == LIM) : (cnt == '0);

endmodule

// File: rtl/sdram_owner_scheduler.sv
// sdram_owner_scheduler: requester-side scheduler driving Nios/accel ownership requests to the SDRAM arbiter
module sdram_owner_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int ACCEL_SLICE    = ACCEL_SLICE_DEF,
    parameter int CAM_GUARD      = CAM_GUARD_DEF,
    parameter int SWITCH_TIMEOUT = SWITCH_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     Reset,
    sdram_owner_scheduler_if.master  bus
);

    localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(CAM_GUARD);
    localparam logic [CNT_W-1:0] SLICE_V = CNT_W'(ACCEL_SLICE - 1);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(SWITCH_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] guard_cnt, slice_cnt, tmo_cnt;
    logic             guard_zero, slice_zero, tmo_done;
    logic             guard_load, slice_load, tmo_load, tmo_en;

    assign guard_load = (state == RELEASE) && (state_nxt == CAM);
    assign slice_load = (state == REQ_ACCEL) && (state_nxt == ACCEL_OWN);
    assign tmo_load   = (state_nxt != state) && is_wait(state_nxt);
    assign tmo_en     = is_wait(state);

    sdram_sched_timer #(.CNT_W(CNT_W)) u_guard (
        .clk(clk), .Reset(Reset), .load(guard_load), .en(state == CAM),
        .val(GUARD_V), .cnt(guard_cnt), .done(guard_zero)
    );

    sdram_sched_timer #(.CNT_W(CNT_W)) u_slice (
        .clk(clk), .Reset(Reset), .load(slice_load), .en(state == ACCEL_OWN),
        .val(SLICE_V), .cnt(slice_cnt), .done(slice_zero)
    );

    // Counts cycles 0..SWITCH_TIMEOUT-1 in a waiting state; being at the limit while still waiting flags the error
    sdram_sched_timer #(.CNT_W(CNT_W), .UP(1'b1), .LIM(TMO_LIM)) u_tmo (
        .clk(clk), .Reset(Reset), .load(tmo_load), .en(tmo_en),
        .val('0), .cnt(tmo_cnt), .done(tmo_done)
    );

    // State register
    always_ff @(posedge clk or posedge Reset)
        if (Reset)
            state <= RELEASE;
        else
            state <= state_nxt;

    // Next-state: Nios beats accel, cam_busy only gates leaving CAM, guard only delays accel
    always_comb begin
        state_nxt = state;
        case (state)
            RELEASE:     state_nxt = bus.CamHasControl ? CAM : RELEASE;
            CAM:         state_nxt = (bus.nios_req && !bus.cam_busy)                ? REQ_NIOS  :
                                     (bus.accel_req && !bus.cam_busy && guard_zero) ? REQ_ACCEL : CAM;
            REQ_NIOS:    state_nxt = !bus.nios_req       ? RELEASE  :
                                     bus.NiosHasControl  ? NIOS_OWN : REQ_NIOS;
            NIOS_OWN:    state_nxt = bus.nios_req ? NIOS_OWN : RELEASE;
            REQ_ACCEL:   state_nxt = bus.nios_req          ? REQ_NIOS  :
                                     bus.AccelHasControl   ? ACCEL_OWN :
                                     !bus.accel_req        ? RELEASE   : REQ_ACCEL;
            ACCEL_OWN:   state_nxt = !bus.accel_req                ? RELEASE     :
                                     (slice_zero || bus.nios_req)  ? ACCEL_YIELD : ACCEL_OWN;
            ACCEL_YIELD: state_nxt = bus.accel_req ? ACCEL_YIELD : RELEASE;
            default:     state_nxt = RELEASE;
        endcase
    end

    // Outputs are registered from the next state so they move on the same edge as the state
    always_ff @(posedge clk or posedge Reset)
        if (Reset) begin
            bus.RequestNiosControl  <= 1'b0;
            bus.RequestAccelControl <= 1'b0;
            bus.nios_grant          <= 1'b0;
            bus.accel_grant         <= 1'b0;
            bus.accel_preempt       <= 1'b0;
            bus.switch_error        <= 1'b0;
        end else begin
            bus.RequestNiosControl  <= state_nxt inside {REQ_NIOS, NIOS_OWN};
            bus.RequestAccelControl <= state_nxt inside {REQ_ACCEL, ACCEL_OWN, ACCEL_YIELD};
            bus.nios_grant          <= state_nxt == NIOS_OWN;
            bus.accel_grant         <= state_nxt inside {ACCEL_OWN, ACCEL_YIELD};
            bus.accel_preempt       <= state_nxt == ACCEL_YIELD;
            bus.switch_error        <= bus.switch_error | (tmo_en & tmo_done);
        end

    assign bus.state_dbg = state;

endmodule

// File: doc/sdram_owner_scheduler.md
Name: sdram_owner_scheduler

Overview:
Requester-side scheduler for the SDRAM ownership arbiter. It collects level requests from the Nios and the accelerator and drives RequestNiosControl/RequestAccelControl. It waits for the arbiter's HasControl handshakes before granting. It enforces Nios priority, an accelerator time slice, a camera guard window and mid-burst safety for the camera.

Parameters:
CNT_W, 16, width of all internal counters
ACCEL_SLICE, 1024, max accel_grant cycles per ownership before preempt
CAM_GUARD, 256, min camera-owned cycles after any release before accel may request (Nios exempt)
SWITCH_TIMEOUT, 64, cycles waiting for arbiter handshake before switch_error sets

Ports:
clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
nios_req  in  1  Nios wants SDRAM; level, held until done
accel_req  in  1  accel wants SDRAM; level; dropping it = accel idle/released
cam_busy  in  1  camera burst in flight; no ownership change may start while high
NiosHasControl  in  1  arbiter status
AccelHasControl  in  1  arbiter status
CamHasControl  in  1  arbiter status
RequestNiosControl  out  1  to arbiter
RequestAccelControl  out  1  to arbiter
nios_grant  out  1  Nios may issue SDRAM commands
accel_grant  out  1  accel may issue SDRAM commands
accel_preempt  out  1  accel must finish current burst and drop accel_req
switch_error  out  1  sticky; handshake exceeded SWITCH_TIMEOUT
state_dbg  out  3  current state encoding

Behaviour:
- All outputs are registered. Moore outputs are decoded from the registered state. The clk-edge after a transition condition updates the outputs.
- Reset asserted (async, mid-operation included): state=RELEASE, all outputs 0, switch_error=0, guard=0, slice=0, timeout=0.
- States and encodings: CAM=0, REQ_NIOS=1, NIOS_OWN=2, REQ_ACCEL=3, ACCEL_OWN=4, ACCEL_YIELD=5, RELEASE=6.
- RELEASE: all Request/grant outputs 0. On CamHasControl=1 -> CAM, guard<=CAM_GUARD. This covers the arbiter's power-up state of Nios ownership.
- CAM: outputs 0. guard decrements to 0 and saturates.
  - nios_req & !cam_busy -> REQ_NIOS. This has priority and ignores guard.
  - else accel_req & !cam_busy & guard==0 -> REQ_ACCEL.
- REQ_NIOS: RequestNiosControl=1. NiosHasControl=1 -> NIOS_OWN. If nios_req drops before the handshake -> RELEASE.
- NIOS_OWN: RequestNiosControl=1, nios_grant=1. !nios_req -> RELEASE. Request and grant fall on the same edge.
- REQ_ACCEL: RequestAccelControl=1.
  - nios_req -> REQ_NIOS. RequestAccel falls and RequestNios rises on the same edge.
  - else AccelHasControl -> ACCEL_OWN, slice<=ACCEL_SLICE-1.
  - else !accel_req -> RELEASE.
- ACCEL_OWN: RequestAccelControl=1, accel_grant=1, slice decrements.
  - !accel_req -> RELEASE.
  - else slice==0 or nios_req -> ACCEL_YIELD.
- ACCEL_YIELD: as ACCEL_OWN plus accel_preempt=1. Unbounded wait for !accel_req -> RELEASE. The Nios is served from CAM afterwards, ahead of guard.
- Timeout counter: clears on entry to REQ_NIOS, REQ_ACCEL or RELEASE, and increments while in them. Reaching SWITCH_TIMEOUT sets switch_error. The counter saturates and the state keeps waiting. switch_error clears only on Reset.
- Simultaneous nios_req and accel_req in CAM: Nios wins. Accel is served after the Nios releases and the guard expires.
- cam_busy is sampled only in CAM. Once a request has been raised, cam_busy is ignored.
- Invariants:
  - RequestNios and RequestAccel are never both 1.
  - nios_grant implies NiosHasControl was seen.
  - accel_grant implies AccelHasControl was seen.
  - Grants are mutually exclusive.
- Counter widths are CNT_W. Parameters must be < 2**CNT_W. ACCEL_SLICE>=1.

Decomposition:
- Shared package sdram_sched_pkg holds:
  - state encodings
  - default constants: ACCEL_SLICE, CAM_GUARD, SWITCH_TIMEOUT
- One sub-module, sdram_sched_timer: a CNT_W loadable down-counter with a zero flag and saturation. It is instantiated for slice and guard. The timeout uses an up-count variant or a separate instance.

Test Plan:
(bench params ACCEL_SLICE=8, CAM_GUARD=4, SWITCH_TIMEOUT=6; arbiter model grants Nios 4 cycles and accel 1 cycle after request, and returns CamHasControl 3 cycles after request drop)
- Reset release, model in Nios ownership -> RELEASE until CamHasControl, then CAM. All outputs 0 throughout. switch_error stays 0 (3<6).
- nios_req=1 at idle -> RequestNios next edge, nios_grant exactly 1 edge after NiosHasControl. Drop nios_req -> both fall next edge, CAM after 3 cycles.
- accel_req held forever -> accel_grant for exactly 8 cycles, then accel_preempt=1. Drop accel_req 2 cycles later -> RELEASE, CAM. Next RequestAccel no earlier than 4 cycles of CAM.
- accel_req and nios_req rising same cycle with cam_busy=1 for 5 cycles -> no request until cam_busy falls, then RequestNios only.
- nios_req during ACCEL_OWN -> accel_preempt next edge. After accel drops: RELEASE -> CAM -> REQ_NIOS with guard bypassed. RequestNios/Accel never overlap.
- Model never asserts NiosHasControl -> switch_error=1 after 6 cycles in REQ_NIOS, state held. Reset mid-wait -> everything 0 asynchronously.
